// File: rtl/mistral_fifo_pkg.sv
// Shared constants and types for the M20K-backed SDP FIFO.
// Skid depth, RAM read latency and the level-width helper live here.
package mistral_fifo_pkg;

    localparam int SKID_DEPTH = 2;
    localparam int RD_LAT     = 1;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    // Bits needed to count every word the FIFO can hold: RAM + skid, inclusive.
    function automatic int level_width(input int abits);
        return $clog2((2 ** abits) + SKID_DEPTH + 1);
    endfunction

endpackage

// File: rtl/mistral_m20k_sdp_ram.sv
// Simple-dual-port storage: write port A, registered read port B (1-cycle latency).
// Behavioural model; the intel_alm flow maps it onto the M20K techmap.
module mistral_m20k_sdp_ram #(
    parameter int ABITS = 10,
    parameter int DBITS = 20
) (
    input  logic             CLK,
    input  logic             i_wen,
    input  logic [ABITS-1:0] i_waddr,
    input  logic [DBITS-1:0] i_wdata,
    input  logic             i_ren,
    input  logic [ABITS-1:0] i_raddr,
    output logic [DBITS-1:0] o_q
);

    logic [DBITS-1:0] r_mem [2**ABITS];
    logic [DBITS-1:0] r_q;

    // NOTE: no reset on the array or its read register -- a block RAM cannot
    // be cleared in one cycle, and resetting it would stop the M20K mapping.
    always_ff @(posedge CLK) begin
        if (i_wen) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_ren) begin
            r_q <= r_mem[i_raddr];
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mistral_m20k_sdp_fifo.sv
// Synchronous FIFO on an M20K SDP pair with a 2-entry skid absorbing read latency.
// Capacity is 2**ABITS RAM words plus SKID_DEPTH skid words.
module mistral_m20k_sdp_fifo
    import mistral_fifo_pkg::*;
#(
    parameter int ABITS = 10,
    parameter int DBITS = 20
) (
    input  logic             CLK,
    input  logic             ACLR,
    input  logic [DBITS-1:0] WDATA,
    input  logic             WVALID,
    output logic             WREADY,
    output logic [DBITS-1:0] RDATA,
    output logic             RVALID,
    input  logic             RREADY,
    output logic [ABITS+1:0] LEVEL
);

    localparam int CNT_W = ABITS + 1;
    localparam int LVL_W = ABITS + 2;
    localparam int OCC_W = $clog2(SKID_DEPTH + RD_LAT + 1) + 1;
    localparam logic [CNT_W-1:0] DEPTH = {1'b1, {ABITS{1'b0}}};

    logic             r_run;
    logic [ABITS-1:0] r_wptr;
    logic [ABITS-1:0] r_rptr;
    logic [CNT_W-1:0] r_ram_count;
    logic             r_inflight;
    skid_state_e      r_skid_st;
    logic [DBITS-1:0] r_head;
    logic [DBITS-1:0] r_tail;
    logic [LVL_W-1:0] r_level;

    logic             w_push;
    logic             w_pop;
    logic             w_issue;
    logic [OCC_W-1:0] w_occ;
    logic [DBITS-1:0] w_ram_q;
    skid_state_e      w_skid_st_nxt;
    logic [DBITS-1:0] w_head_nxt;
    logic [DBITS-1:0] w_tail_nxt;

    // r_run keeps WREADY low while ACLR is asserted even though ram_count is 0.
    assign WREADY = r_run && (r_ram_count != DEPTH);
    assign RVALID = (r_skid_st != SKID_EMPTY);
    assign RDATA  = r_head;
    assign LEVEL  = r_level;

    assign w_push  = WVALID && WREADY;
    assign w_pop   = RVALID && RREADY;
    assign w_occ   = OCC_W'(r_skid_st) + OCC_W'(r_inflight);
    assign w_issue = (r_ram_count != '0) &&
                     (w_occ < (OCC_W'(SKID_DEPTH) + OCC_W'(w_pop)));

    mistral_m20k_sdp_ram #(
        .ABITS (ABITS),
        .DBITS (DBITS)
    ) u_ram (
        .CLK     (CLK),
        .i_wen   (w_push),
        .i_waddr (r_wptr),
        .i_wdata (WDATA),
        .i_ren   (w_issue),
        .i_raddr (r_rptr),
        .o_q     (w_ram_q)
    );

    // Skid next state. The issue rule guarantees no arrival into a full skid
    // unless the same cycle pops, so SKID_TWO only needs the pop cases.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        w_skid_st_nxt = r_skid_st;
        w_head_nxt    = r_head;
        w_tail_nxt    = r_tail;
        case (r_skid_st)
            SKID_EMPTY: begin
                if (r_inflight) begin
                    w_head_nxt    = w_ram_q;
                    w_skid_st_nxt = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (w_pop && r_inflight) begin
                    w_head_nxt = w_ram_q;
                end else if (w_pop) begin
                    w_skid_st_nxt = SKID_EMPTY;
                end else if (r_inflight) begin
                    w_tail_nxt    = w_ram_q;
                    w_skid_st_nxt = SKID_TWO;
                end
            end
            default: begin
                if (w_pop) begin
                    w_head_nxt = r_tail;
                    if (r_inflight) begin
                        w_tail_nxt = w_ram_q;
                    end else begin
                        w_skid_st_nxt = SKID_ONE;
                    end
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge ACLR) begin
        if (!ACLR) begin
            r_run       <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_ram_count <= '0;
            r_inflight  <= 1'b0;
            r_skid_st   <= SKID_EMPTY;
            r_head      <= '0;
            r_tail      <= '0;
            r_level     <= '0;
        end else begin
            r_run      <= 1'b1;
            r_inflight <= w_issue;
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_issue) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_ram_count <= r_ram_count + CNT_W'(w_push) - CNT_W'(w_issue);
            r_level     <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
            r_skid_st   <= w_skid_st_nxt;
            r_head      <= w_head_nxt;
            r_tail      <= w_tail_nxt;
        end
    end

endmodule

// File: tb/tb_mistral_m20k_sdp_fifo.sv
// Directed and randomised bench for mistral_m20k_sdp_fifo (ABITS=4, DBITS=8).
// A queue scoreboard supplies expected data; LEVEL is compared against its size.
module tb_mistral_m20k_sdp_fifo;

    logic       CLK;
    logic       ACLR;
    logic [7:0] WDATA;
    logic       WVALID;
    logic       WREADY;
    logic [7:0] RDATA;
    logic       RVALID;
    logic       RREADY;
    logic [5:0] LEVEL;

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_pops   = 0;
    int         n_pushes = 0;
    logic [7:0] sb[$];
    logic       prev_hold = 1'b0;
    logic [7:0] prev_rdata = 8'h00;

    mistral_m20k_sdp_fifo #(
        .ABITS (4),
        .DBITS (8)
    ) dut (
        .CLK    (CLK),
        .ACLR   (ACLR),
        .WDATA  (WDATA),
        .WVALID (WVALID),
        .WREADY (WREADY),
        .RDATA  (RDATA),
        .RVALID (RVALID),
        .RREADY (RREADY),
        .LEVEL  (LEVEL)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check outputs at the falling edge, update the
    // scoreboard at the rising edge, then compare LEVEL just after it.
    task automatic cycle(input logic wv, input logic [7:0] wd, input logic rr);
        logic push;
        logic pop;
        WVALID = wv;
        WDATA  = wd;
        RREADY = rr;
        @(negedge CLK);
        push = WVALID && WREADY;
        pop  = RVALID && RREADY;
        if (prev_hold) begin
            check("hold_rvalid", RVALID, 1);
            check("hold_rdata", RDATA, prev_rdata);
        end
        if (RVALID) begin
            if (sb.size() == 0) check("rvalid_unexpected", RVALID, 0);
            else                check("rdata_order", RDATA, sb[0]);
        end
        prev_hold  = RVALID && !RREADY;
        prev_rdata = RDATA;
        @(posedge CLK);
        if (pop && sb.size() != 0) begin
            void'(sb.pop_front());
            n_pops++;
        end
        if (push) begin
            sb.push_back(wd);
            n_pushes++;
        end
        #1;
        check("level", LEVEL, sb.size());
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && sb.size() != 0; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
        end
        check("drain_level", LEVEL, 0);
        check("drain_rvalid", RVALID, 0);
    endtask

    initial begin
        int start;
        ACLR   = 1'b0;
        WVALID = 1'b0;
        RREADY = 1'b0;
        WDATA  = 8'h00;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check("rst_wready", WREADY, 0);
        check("rst_rvalid", RVALID, 0);
        check("rst_level", LEVEL, 0);
        check("rst_rdata", RDATA, 0);
        ACLR = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("idle_wready", WREADY, 1);
        check("idle_rvalid", RVALID, 0);
        check("idle_level", LEVEL, 0);

        // First-word latency: push at edge t, RVALID after edge t+2
        cycle(1'b1, 8'hA5, 1'b0);
        check("lat_t0_rvalid", RVALID, 0);
        check("lat_t0_level", LEVEL, 1);
        cycle(1'b0, 8'h00, 1'b0);
        check("lat_t1_rvalid", RVALID, 0);
        cycle(1'b0, 8'h00, 1'b0);
        check("lat_t2_rvalid", RVALID, 1);
        check("lat_t2_rdata", RDATA, 8'hA5);
        cycle(1'b0, 8'h00, 1'b1);
        check("lat_pop_rvalid", RVALID, 0);

        // Fill to capacity (16 RAM + 2 skid), 19th write refused
        for (int i = 0; i < 18; i++) begin
            check("fill_wready", WREADY, 1);
            cycle(1'b1, 8'(i), 1'b0);
        end
        check("full_wready", WREADY, 0);
        check("full_level", LEVEL, 18);
        check("full_head", RDATA, 8'h00);
        cycle(1'b1, 8'h99, 1'b0);
        check("full_level_hold", LEVEL, 18);
        check("full_wready_hold", WREADY, 0);
        start = n_pops;
        drain(40);
        check("fill_drained", n_pops - start, 18);

        // Streaming: one pop per cycle once the 2-cycle fill is done
        start = n_pops;
        for (int k = 0; k < 100; k++) begin
            cycle(1'b1, 8'(k + 8'h40), 1'b1);
            if (k >= 2) check("stream_rvalid", RVALID, 1);
        end
        check("stream_pops", n_pops - start, 97);
        drain(10);

        // Random valid/ready with scoreboard
        start = n_pushes;
        for (int c = 0; c < 6000 && (n_pushes - start) < 1000; c++) begin
            cycle(($urandom_range(0, 9) < 7), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        check("rand_pushed", n_pushes - start, 1000);
        drain(50);

        // Three full fill/drain rounds across the pointer rollover
        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 0; i < 18; i++) begin
                cycle(1'b1, 8'(rep * 32 + i + 8'h80), 1'b0);
            end
            check("wrap_full_level", LEVEL, 18);
            start = n_pops;
            drain(40);
            check("wrap_drained", n_pops - start, 18);
        end

        // Reset with LEVEL=9 and a read in flight
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'(8'h50 + i), 1'b0);
        end
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        check("pre_rst_level", LEVEL, 9);
        RREADY = 1'b0;
        ACLR   = 1'b0;
        #1;
        check("mid_rst_rvalid", RVALID, 0);
        check("mid_rst_level", LEVEL, 0);
        check("mid_rst_wready", WREADY, 0);
        check("mid_rst_rdata", RDATA, 0);
        sb.delete();
        prev_hold = 1'b0;
        @(posedge CLK);
        #1;
        ACLR = 1'b1;
        @(posedge CLK);
        #1;
        check("post_rst_wready", WREADY, 1);
        check("post_rst_level", LEVEL, 0);
        cycle(1'b1, 8'h3C, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        check("post_rst_rvalid", RVALID, 1);
        check("post_rst_first", RDATA, 8'h3C);
        drain(5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
